// File: rtl/ins_cache_ctrl_pkg.sv
// ins_cache_ctrl_pkg: definitions shared by the instruction cache controller
// and its line array.
//   DAT_W          width of the instruction window returned to the fetcher
//   ICACHE_IDX_W   default number of line index bits
//   ICACHE_OFF_W   default number of byte offset bits (line = 2^OFF_W bytes)
//   ic_state_t     fill FSM encodings (IDLE, FILL, PREF)
package ins_cache_ctrl_pkg;

    localparam int DAT_W        = 32;
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_OFF_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PREF = 2'd2
    } ic_state_t;

endpackage

// File: rtl/ic_line_array.sv
// ic_line_array: tag, valid and data storage for the direct-mapped
// instruction cache.
//   clk, rst                  clock, synchronous active-high reset (clears valid bits only)
//   rd_idx_a/b                index of the two combinational read ports
//   rd_vld_a/b, rd_tag_a/b    valid bit and stored tag of each read port
//   rd_data_a/b               whole line, byte 0 in bits [7:0]
//   pr_idx/pr_vld/pr_tag      tag probe for the next-line prefetch decision
//                             (present only with ICACHE_NEXTLINE_PREFETCH_EN)
//   wr_en/wr_idx/wr_tag/wr_data  atomic line commit port
import ins_cache_ctrl_pkg::*;

module ic_line_array #(
    parameter int IDX_W  = ICACHE_IDX_W,
    parameter int OFF_W  = ICACHE_OFF_W,
    parameter int TAG_W  = 32 - IDX_W - OFF_W,
    parameter int LINE_W = 8 * (2 ** OFF_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx_a,
    output logic              rd_vld_a,
    output logic [TAG_W-1:0]  rd_tag_a,
    output logic [LINE_W-1:0] rd_data_a,
    input  logic [IDX_W-1:0]  rd_idx_b,
    output logic              rd_vld_b,
    output logic [TAG_W-1:0]  rd_tag_b,
    output logic [LINE_W-1:0] rd_data_b,
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    input  logic [IDX_W-1:0]  pr_idx,
    output logic              pr_vld,
    output logic [TAG_W-1:0]  pr_tag,
`endif
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    localparam int NLINES = 2 ** IDX_W;

    logic [NLINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_mem  [NLINES];
    logic [LINE_W-1:0] data_mem [NLINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only visible through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_vld_a  = valid_q[rd_idx_a];
    assign rd_tag_a  = tag_mem[rd_idx_a];
    assign rd_data_a = data_mem[rd_idx_a];
    assign rd_vld_b  = valid_q[rd_idx_b];
    assign rd_tag_b  = tag_mem[rd_idx_b];
    assign rd_data_b = data_mem[rd_idx_b];

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    assign pr_vld = valid_q[pr_idx];
    assign pr_tag = tag_mem[pr_idx];
`endif

endmodule

// File: rtl/ins_cache_ctrl.sv
// ins_cache_ctrl: direct-mapped instruction cache with a combinational
// lookup (RV32I / RV32C, including 32-bit instructions straddling two lines)
// and a byte-serial line fill from the memory controller.
//   clk, rst      clock, synchronous active-high reset
//   en            global enable; low freezes the FSM and the line array
//   if_pc_i       fetch PC (halfword aligned)
//   if_en_i       fill request from the fetcher on a miss
//   if_en_o       hit: if_ins_o holds bytes pc..pc+3 (little-endian)
//   if_ins_o      instruction window
//   mc_en_o       line-fill request, held for the whole fill
//   mc_addr_o     base address of the line being filled
//   mc_vld_i      mc_byte_i carries the next sequential byte of the line
//   mc_byte_i     fill byte
// Build option: define ICACHE_NEXTLINE_PREFETCH_EN to fill line L+1 right
// after a demand fill of line L when L+1 is not resident.
import ins_cache_ctrl_pkg::*;

module ins_cache_ctrl #(
    parameter int IDX_W = ICACHE_IDX_W,
    parameter int OFF_W = ICACHE_OFF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      if_pc_i,
    input  logic             if_en_i,
    output logic             if_en_o,
    output logic [DAT_W-1:0] if_ins_o,
    output logic             mc_en_o,
    output logic [31:0]      mc_addr_o,
    input  logic             mc_vld_i,
    input  logic [7:0]       mc_byte_i
);

    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LNUM_W = 32 - OFF_W;          // line number = {tag, idx}
    localparam int LINE_B = 2 ** OFF_W;
    localparam int LINE_W = 8 * LINE_B;

    // Lookup: line A holds pc, line B is the next line (used for straddles)
    logic [LNUM_W-1:0] lnum_a, lnum_b;
    logic [OFF_W-1:0]  off;
    logic              vld_a, vld_b;
    logic [TAG_W-1:0]  rtag_a, rtag_b;
    logic [LINE_W-1:0] data_a, data_b;
    logic              hit_a, hit_b, straddle;
    logic [2*LINE_W-1:0] win;

    assign lnum_a = if_pc_i[31:OFF_W];
    assign lnum_b = lnum_a + LNUM_W'(1);
    assign off    = if_pc_i[OFF_W-1:0];

    assign hit_a = vld_a && (rtag_a == lnum_a[LNUM_W-1:IDX_W]);
    assign hit_b = vld_b && (rtag_b == lnum_b[LNUM_W-1:IDX_W]);

    // A 32-bit encoding (low bits 11) starting in the last halfword spills into line B.
    assign straddle = (off == OFF_W'(LINE_B - 2)) && (data_a[{off, 3'b000} +: 2] == 2'b11);

    assign if_en_o  = hit_a && (!straddle || hit_b);
    assign win      = {data_b, data_a};
    assign if_ins_o = win[{off, 3'b000} +: DAT_W];

    // Fill FSM
    ic_state_t         state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [LNUM_W-1:0] fill_lnum_q, fill_lnum_d;
    logic [LINE_W-1:0] stage_q;
    logic              commit;
    logic [LINE_W-1:0] commit_data;

    // The last byte bypasses the staging buffer so the line commits on its edge.
    assign commit_data = {mc_byte_i, stage_q[LINE_W-9:0]};

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    logic [LNUM_W-1:0] next_lnum;
    logic              next_vld;
    logic [TAG_W-1:0]  next_rtag;
    logic              next_hit;

    assign next_lnum = fill_lnum_q + LNUM_W'(1);
    assign next_hit  = next_vld && (next_rtag == next_lnum[LNUM_W-1:IDX_W]);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_lnum_d = fill_lnum_q;
        commit      = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (if_en_i && !if_en_o) begin
                        state_d     = FILL;
                        cnt_d       = '0;
                        fill_lnum_d = hit_a ? lnum_b : lnum_a;
                    end
                end
                FILL, PREF: begin
                    if (mc_vld_i) begin
                        cnt_d = cnt_q + OFF_W'(1);
                        if (cnt_q == '1) begin
                            commit  = 1'b1;
                            state_d = IDLE;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
                            // Only a demand fill may trigger a prefetch; PREF never chains.
                            if (state_q == FILL && !next_hit) begin
                                state_d     = PREF;
                                fill_lnum_d = next_lnum;
                            end
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_lnum_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_lnum_q <= fill_lnum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en && mc_en_o && mc_vld_i) begin
            stage_q[{cnt_q, 3'b000} +: 8] <= mc_byte_i;
        end
    end

    assign mc_en_o   = (state_q != IDLE);
    assign mc_addr_o = {fill_lnum_q, OFF_W'(0)};

    ic_line_array #(
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_a  (lnum_a[IDX_W-1:0]),
        .rd_vld_a  (vld_a),
        .rd_tag_a  (rtag_a),
        .rd_data_a (data_a),
        .rd_idx_b  (lnum_b[IDX_W-1:0]),
        .rd_vld_b  (vld_b),
        .rd_tag_b  (rtag_b),
        .rd_data_b (data_b),
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
        .pr_idx    (next_lnum[IDX_W-1:0]),
        .pr_vld    (next_vld),
        .pr_tag    (next_rtag),
`endif
        .wr_en     (commit),
        .wr_idx    (fill_lnum_q[IDX_W-1:0]),
        .wr_tag    (fill_lnum_q[LNUM_W-1:IDX_W]),
        .wr_data   (commit_data)
    );

endmodule

// File: tb/tb_ins_cache_ctrl.sv
// tb_ins_cache_ctrl: directed bench for ins_cache_ctrl (default parameters,
// 16 lines of 16 bytes). A line-level cache model tracks resident lines and
// the outstanding fill; a negedge process compares every cycle, and the
// directed sequence adds hand-computed literal expectations.
module tb_ins_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [31:0] if_pc_i;
    logic        if_en_i;
    logic        if_en_o;
    logic [31:0] if_ins_o;
    logic        mc_en_o;
    logic [31:0] mc_addr_o;
    logic        mc_vld_i;
    logic [7:0]  mc_byte_i;

    int n_chk = 0;
    int n_err = 0;
    bit started = 1'b0;

    logic [7:0] mem [0:1023];

    ins_cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .if_pc_i   (if_pc_i),
        .if_en_i   (if_en_i),
        .if_en_o   (if_en_o),
        .if_ins_o  (if_ins_o),
        .mc_en_o   (mc_en_o),
        .mc_addr_o (mc_addr_o),
        .mc_vld_i  (mc_vld_i),
        .mc_byte_i (mc_byte_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- cache model ----------------
    logic        m_vld [16];
    logic [23:0] m_tag [16];
    logic [7:0]  m_dat [16][16];
    logic [7:0]  m_buf [16];
    logic        m_busy, m_pref;
    logic [31:0] m_addr;
    int          m_n;

    function automatic logic present(input logic [31:0] a);
        return m_vld[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
    endfunction

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        return m_dat[a[7:4]][a[3:0]];
    endfunction

    function automatic logic exp_hit(input logic [31:0] pc);
        logic [7:0] b0;
        if (!present(pc)) return 1'b0;
        b0 = mbyte(pc);
        if (pc[3:0] == 4'hE && b0[1:0] == 2'b11) return present(pc + 32'd16);
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
            m_busy = 1'b0; m_pref = 1'b0; m_addr = '0; m_n = 0;
        end else if (en) begin
            if (!m_busy) begin
                if (if_en_i && !exp_hit(if_pc_i)) begin
                    m_busy = 1'b1; m_pref = 1'b0; m_n = 0;
                    m_addr = present(if_pc_i) ? ((if_pc_i + 32'd16) & ~32'hF) : (if_pc_i & ~32'hF);
                end
            end else if (mc_vld_i) begin
                m_buf[m_n] = mc_byte_i;
                m_n++;
                if (m_n == 16) begin
                    m_vld[m_addr[7:4]] = 1'b1;
                    m_tag[m_addr[7:4]] = m_addr[31:8];
                    for (int i = 0; i < 16; i++) m_dat[m_addr[7:4]][i] = m_buf[i];
                    m_busy = 1'b0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
                    if (!m_pref && !present(m_addr + 32'd16)) begin
                        m_busy = 1'b1; m_pref = 1'b1; m_n = 0;
                        m_addr = m_addr + 32'd16;
                    end
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            logic       h;
            logic [7:0] b0;
            h = exp_hit(if_pc_i);
            check("mc_en", {31'd0, mc_en_o}, {31'd0, m_busy});
            if (m_busy) check("mc_addr", mc_addr_o, m_addr);
            check("hit", {31'd0, if_en_o}, {31'd0, h});
            if (h && if_en_o) begin
                b0 = mbyte(if_pc_i);
                if (b0[1:0] == 2'b11)
                    check("ins32", if_ins_o, {mbyte(if_pc_i + 3), mbyte(if_pc_i + 2),
                                             mbyte(if_pc_i + 1), b0});
                else
                    check("ins16", {16'd0, if_ins_o[15:0]}, {16'd0, mbyte(if_pc_i + 1), b0});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic request(input logic [31:0] pc);
        if_pc_i = pc;
        if_en_i = 1'b1;
        step();
        if_en_i = 1'b0;
    endtask

    // Serve bytes [first, last) of the fill in progress, with gap idle cycles after each.
    task automatic serve(input int gap, input int first, input int last, output logic [31:0] a);
        int k = 0;
        a = '0;
        while (!mc_en_o && k < 20) begin
            step();
            k++;
        end
        if (!mc_en_o) begin
            check("fill_start_timeout", 32'd0, 32'd1);
            return;
        end
        a = mc_addr_o;
        for (int i = first; i < last; i++) begin
            mc_vld_i  = 1'b1;
            mc_byte_i = mem[a[9:0] + 10'(i)];
            step();
            mc_vld_i  = 1'b0;
            repeat (gap) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ {i[9:8], 6'd0};
        rst = 1'b1; en = 1'b1; if_pc_i = '0; if_en_i = 1'b0;
        mc_vld_i = 1'b0; mc_byte_i = '0;
        step();
        started = 1'b1;
        check("rst_mc_en", {31'd0, mc_en_o}, 32'd0);
        check("rst_mc_addr", mc_addr_o, 32'd0);
        check("rst_hit", {31'd0, if_en_o}, 32'd0);
        rst = 1'b0;
        step();

        // Cold miss at 0x0
        request(32'h0);
        check("cold_mc_en", {31'd0, mc_en_o}, 32'd1);
        check("cold_mc_addr", mc_addr_o, 32'h0);
        serve(0, 0, 16, a);
        check("cold_hit", {31'd0, if_en_o}, 32'd1);
        check("cold_ins", if_ins_o, 32'h03020100);
`ifndef ICACHE_NEXTLINE_PREFETCH_EN
        check("cold_idle", {31'd0, mc_en_o}, 32'd0);
`endif
        do_reset();

        // Conflict: 0x100 maps onto line 0's index
        request(32'h0);
        serve(0, 0, 16, a);
        do_reset();
        request(32'h0);
        serve(0, 0, 16, a);
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
        serve(0, 0, 16, a);
`endif
        request(32'h100);
        check("conf_mc_addr", mc_addr_o, 32'h100);
        serve(0, 0, 16, a);
        check("conf_ins", if_ins_o, 32'h43424140);
        if_pc_i = 32'h0;
        step();
        check("conf_old_miss", {31'd0, if_en_o}, 32'd0);

        // Straddle: 32-bit instruction at 0x0E spans lines 0 and 1
        mem[14] = 8'h13;
        do_reset();
        request(32'h0);
        serve(0, 0, 16, a);
        if_pc_i = 32'h0E;
        step();
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
        check("strad_pref_addr", mc_addr_o, 32'h10);
        serve(0, 0, 16, a);
`else
        check("strad_miss", {31'd0, if_en_o}, 32'd0);
        request(32'h0E);
        check("strad_mc_addr", mc_addr_o, 32'h10);
        serve(0, 0, 16, a);
`endif
        check("strad_hit", {31'd0, if_en_o}, 32'd1);
        check("strad_ins", if_ins_o, 32'h11100F13);

        // Same pc, compressed: hits with line 1 still invalid
        mem[14] = 8'h01;
        do_reset();
        request(32'h0);
        serve(0, 0, 16, a);
        if_pc_i = 32'h0E;
        #1;
        check("comp_hit", {31'd0, if_en_o}, 32'd1);
        check("comp_ins", {16'd0, if_ins_o[15:0]}, 32'h00000F01);
        mem[14] = 8'h0E;

        // Gapped fill with an enable-low pause before the last byte
        do_reset();
        request(32'h40);
        serve(3, 0, 15, a);
        check("gap_no_hit", {31'd0, if_en_o}, 32'd0);
        check("gap_addr", mc_addr_o, 32'h40);
        en = 1'b0; mc_vld_i = 1'b1; mc_byte_i = 8'hEE;
        step(); step();
        en = 1'b1; mc_vld_i = 1'b0;
        check("gap_en_hold", {31'd0, if_en_o}, 32'd0);
        serve(3, 15, 16, a);
        check("gap_hit", {31'd0, if_en_o}, 32'd1);
        check("gap_ins", if_ins_o, 32'h43424140);

        // Reset after byte 7 of a fill
        do_reset();
        request(32'h0);
        serve(0, 0, 8, a);
        do_reset();
        check("rstmid_mc_en", {31'd0, mc_en_o}, 32'd0);
        if_pc_i = 32'h0;
        mc_vld_i = 1'b1;
        step();
        mc_vld_i = 1'b0;
        check("rstmid_miss", {31'd0, if_en_o}, 32'd0);
        check("rstmid_idle", {31'd0, mc_en_o}, 32'd0);

        // Demand fill of 0x20, then next-line behaviour
        do_reset();
        request(32'h20);
        serve(0, 0, 16, a);
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
        check("pref_mc_en", {31'd0, mc_en_o}, 32'd1);
        check("pref_addr", mc_addr_o, 32'h30);
        serve(0, 0, 16, a);
        step();
        check("pref_no_chain", {31'd0, mc_en_o}, 32'd0);
        if_pc_i = 32'h30;
        step();
        check("pref_hit", {31'd0, if_en_o}, 32'd1);
`else
        check("nopref_idle", {31'd0, mc_en_o}, 32'd0);
        step(); step();
        check("nopref_idle2", {31'd0, mc_en_o}, 32'd0);
        if_pc_i = 32'h30;
        step();
        check("nopref_miss", {31'd0, if_en_o}, 32'd0);
`endif
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
